// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: write-back arbiter bus.
// Sources: primary write-back (p_*), secondary request with valid/ready (s_*).
// Sinks: register-file write port (we/wn/d) and status (busy/empty/count/ord_err).
interface regfile_wb_arbiter_if #(parameter int AW = 2);
  logic          p_we;
  logic [4:0]    p_wn;
  logic [31:0]   p_d;
  logic          s_valid;
  logic [4:0]    s_wn;
  logic [31:0]   s_d;
  logic          s_ready;
  logic          we;
  logic [4:0]    wn;
  logic [31:0]   d;
  logic [31:0]   busy;
  logic          empty;
  logic [AW:0]   count;
  logic          ord_err;
  modport master (
    output p_we, p_wn, p_d, s_valid, s_wn, s_d,
    input  s_ready, we, wn, d, busy, empty, count, ord_err
  );
  modport slave (
    input  p_we, p_wn, p_d, s_valid, s_wn, s_d,
    output s_ready, we, wn, d, busy, empty, count, ord_err
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: merges never-stalled primary write-back with a FIFO-buffered secondary source onto one register-file write port.
// Ports: clk, clrn (async active-low reset), bus (slave modport: p_*, s_* inputs; s_ready, we/wn/d, busy, empty, count, ord_err outputs).
module regfile_wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic                   clk,
  input  logic                   clrn,
  regfile_wb_arbiter_if.slave    bus
);
  logic [DEPTH-1:0][4:0]  wn_q, wn_d;
  logic [DEPTH-1:0][31:0] d_q, d_d;
  logic [DEPTH-1:0]       v_q, v_d;
  logic [AW-1:0]          rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]            cnt_q, cnt_d;
  logic                   ord_q, ord_d;
  logic                   p_use, empty, push, pop;
  logic [31:0]            busy;
  assign p_use       = bus.p_we && bus.p_wn != 5'd0;
  assign empty       = cnt_q == '0;
  // count never exceeds DEPTH, so its top bit alone marks full
  assign bus.s_ready = !cnt_q[AW];
  assign push        = bus.s_valid && bus.s_ready && bus.s_wn != 5'd0;
  assign pop         = !p_use && !empty;
  assign bus.we      = p_use || !empty;
  assign bus.wn      = p_use ? bus.p_wn : (!empty ? wn_q[rd_q] : 5'd0);
  assign bus.d       = p_use ? bus.p_d : (!empty ? d_q[rd_q] : 32'd0);
  assign bus.busy    = busy;
  assign bus.empty   = empty;
  assign bus.count   = cnt_q;
  assign bus.ord_err = ord_q;
  always_comb begin
    busy = '0;
    for (int i = 0; i < DEPTH; i++)
      if (v_q[i]) busy[wn_q[i]] = 1'b1;
    busy[0] = 1'b0;
  end
  always_comb begin
    wn_d  = wn_q;
    d_d   = d_q;
    v_d   = v_q;
    rd_d  = rd_q + AW'(pop);
    wr_d  = wr_q + AW'(push);
    cnt_d = cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    ord_d = p_use && busy[bus.p_wn];
    if (pop) v_d[rd_q] = 1'b0;
    if (push) begin
      wn_d[wr_q] = bus.s_wn;
      d_d[wr_q]  = bus.s_d;
      v_d[wr_q]  = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      wn_q  <= '0;
      d_q   <= '0;
      v_q   <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      ord_q <= 1'b0;
    end else begin
      wn_q  <= wn_d;
      d_q   <= d_d;
      v_q   <= v_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      ord_q <= ord_d;
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed vector and sequence checks for regfile_wb_arbiter.
module tb_regfile_wb_arbiter;
  logic clk = 1'b0;
  logic clrn = 1'b0;
  int   pass = 0;
  int   total = 0;
  regfile_wb_arbiter_if #(.AW(2)) bus ();
  regfile_wb_arbiter #(.DEPTH(4), .AW(2)) dut (.clk(clk), .clrn(clrn), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic        p_we;
    logic [4:0]  p_wn;
    logic [31:0] p_d;
    logic        e_we;
    logic [4:0]  e_wn;
    logic [31:0] e_d;
  } vec_t;
  vec_t vecs [5];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a === e) pass++;
    else $display("FAIL %s: got %h want %h", n, a, e);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 5'd5,  32'hDEADBEEF};
    vecs[1] = '{1'b1, 5'd0,  32'h00001234, 1'b0, 5'd0,  32'h0};
    vecs[2] = '{1'b0, 5'd9,  32'h0000ABCD, 1'b0, 5'd0,  32'h0};
    vecs[3] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b1, 5'd31, 32'hFFFFFFFF};
    vecs[4] = '{1'b1, 5'd1,  32'h00000000, 1'b1, 5'd1,  32'h0};
    bus.p_we = 0; bus.p_wn = 0; bus.p_d = 0;
    bus.s_valid = 0; bus.s_wn = 0; bus.s_d = 0;
    #12;
    chk("rst_we", bus.we, 0);
    chk("rst_ready", bus.s_ready, 1);
    chk("rst_empty", bus.empty, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_ord", bus.ord_err, 0);
    clrn = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      bus.p_we = vecs[i].p_we; bus.p_wn = vecs[i].p_wn; bus.p_d = vecs[i].p_d;
      #1;
      chk($sformatf("vec%0d_we", i), bus.we, vecs[i].e_we);
      chk($sformatf("vec%0d_wn", i), bus.wn, vecs[i].e_wn);
      chk($sformatf("vec%0d_d", i), bus.d, vecs[i].e_d);
    end
    bus.p_we = 0;
    tick();
    // secondary only
    bus.s_valid = 1; bus.s_wn = 7; bus.s_d = 32'h11;
    #1;
    chk("sec_ready", bus.s_ready, 1);
    chk("sec_we0", bus.we, 0);
    tick();
    bus.s_valid = 0;
    #1;
    chk("sec_we", bus.we, 1);
    chk("sec_wn", bus.wn, 7);
    chk("sec_d", bus.d, 32'h11);
    chk("sec_busy", bus.busy, 32'h80);
    tick();
    chk("sec_busy_clr", bus.busy, 0);
    chk("sec_empty", bus.empty, 1);
    chk("sec_we_idle", bus.we, 0);
    // contention: primary holds the slot while four secondaries queue
    bus.p_we = 1; bus.p_wn = 3; bus.p_d = 32'hAAAA;
    for (int i = 0; i < 4; i++) begin
      bus.s_valid = 1; bus.s_wn = 5'(8 + i); bus.s_d = 32'h80 + i;
      #1;
      chk($sformatf("cont_ready%0d", i), bus.s_ready, 1);
      tick();
    end
    chk("cont_full_ready", bus.s_ready, 0);
    chk("cont_count", bus.count, 4);
    chk("cont_busy", bus.busy, 32'h0000_0F00);
    chk("cont_wn_prim", bus.wn, 3);
    tick();
    chk("cont_still_full", bus.count, 4);
    bus.s_valid = 0;
    bus.p_we = 0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d_we", i), bus.we, 1);
      chk($sformatf("drain%0d_wn", i), bus.wn, 8 + i);
      chk($sformatf("drain%0d_d", i), bus.d, 32'h80 + i);
      tick();
    end
    chk("drain_empty", bus.empty, 1);
    chk("drain_we", bus.we, 0);
    // ordering violation
    bus.p_we = 1; bus.p_wn = 3;
    bus.s_valid = 1; bus.s_wn = 9; bus.s_d = 32'h99;
    tick();
    bus.s_valid = 0;
    bus.p_wn = 9; bus.p_d = 32'h55;
    #1;
    chk("ord_wn", bus.wn, 9);
    chk("ord_pre", bus.ord_err, 0);
    tick();
    bus.p_wn = 3;
    chk("ord_set", bus.ord_err, 1);
    tick();
    chk("ord_clr", bus.ord_err, 0);
    bus.p_we = 0;
    #1;
    chk("ord_q_d", bus.d, 32'h99);
    tick();
    chk("ord_empty", bus.empty, 1);
    // push and pop together at count 2
    bus.p_we = 1;
    for (int i = 0; i < 2; i++) begin
      bus.s_valid = 1; bus.s_wn = 5'(12 + i); bus.s_d = 32'h200 + i;
      tick();
    end
    bus.p_we = 0; bus.s_wn = 14; bus.s_d = 32'h202;
    #1;
    chk("pp_wn", bus.wn, 12);
    tick();
    bus.s_valid = 0;
    chk("pp_count", bus.count, 2);
    for (int i = 1; i < 3; i++) begin
      chk($sformatf("pp_d%0d", i), bus.d, 32'h200 + i);
      tick();
    end
    chk("pp_empty", bus.empty, 1);
    // wrap: ten back-to-back push/pop pairs
    for (int i = 0; i < 10; i++) begin
      bus.s_valid = 1; bus.s_wn = 5'(20 + i); bus.s_d = 32'h100 + i;
      #1;
      if (i > 0) begin
        chk($sformatf("wrap%0d_d", i), bus.d, 32'h100 + i - 1);
        chk($sformatf("wrap%0d_cnt", i), bus.count, 1);
      end
      tick();
    end
    bus.s_valid = 0;
    #1;
    chk("wrap_last", bus.d, 32'h109);
    tick();
    chk("wrap_empty", bus.empty, 1);
    // r0 push completes handshake but is dropped
    bus.s_valid = 1; bus.s_wn = 0; bus.s_d = 32'h77;
    #1;
    chk("r0_ready", bus.s_ready, 1);
    tick();
    bus.s_valid = 0;
    #1;
    chk("r0_count", bus.count, 0);
    chk("r0_we", bus.we, 0);
    // asynchronous reset mid-drain
    bus.p_we = 1; bus.p_wn = 3;
    for (int i = 0; i < 3; i++) begin
      bus.s_valid = 1; bus.s_wn = 5'(4 + i); bus.s_d = 32'h300 + i;
      tick();
    end
    bus.s_valid = 0; bus.p_we = 0;
    #1;
    chk("md_count", bus.count, 3);
    chk("md_we", bus.we, 1);
    #1;
    clrn = 0;
    #1;
    chk("md_rst_count", bus.count, 0);
    chk("md_rst_we", bus.we, 0);
    chk("md_rst_busy", bus.busy, 0);
    tick();
    clrn = 1;
    tick();
    chk("md_after_we", bus.we, 0);
    chk("md_after_empty", bus.empty, 1);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
